// File: rtl/contador_modulo_ud.sv
// contador_modulo_ud: up/down modulo counter with load, clear, wrap/saturate and terminal count.
// tc is combinational so a downstream counter can chain its habilitar on it.
module contador_modulo_ud #(
    parameter int N      = 10,
    parameter int MODULO = 800,
    parameter int SATURA = 0
) (
    input  logic         reloj,
    input  logic         reset,
    input  logic         habilitar,
    input  logic         direccion,
    input  logic         limpiar,
    input  logic         cargar,
    input  logic [N-1:0] valor_carga,
    input  logic         limpiar_desborde,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         desborde
);
    localparam logic [N-1:0] MAX = N'(MODULO - 1);
    localparam bit           SAT = SATURA != 0;

    if (MODULO < 2 || 64'(MODULO) > (64'd1 << N)) begin : g_bad_modulo
        $error("contador_modulo_ud: MODULO must lie in 2..2**N");
    end

    logic [N-1:0] cnt_q, cnt_d, up_v, dn_v;
    logic         ovf_q, ovf_d;

    always_comb begin
        up_v  = cnt_q == MAX ? (SAT ? cnt_q : '0) : cnt_q + 1'b1;
        dn_v  = cnt_q == '0 ? (SAT ? cnt_q : MAX) : cnt_q - 1'b1;
        cnt_d = limpiar   ? '0 :
                cargar    ? (valor_carga > MAX ? MAX : valor_carga) :
                habilitar ? (direccion ? up_v : dn_v) : cnt_q;
        ovf_d = tc | (ovf_q & ~limpiar_desborde);
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign tc       = habilitar & ~limpiar & ~cargar & (direccion ? cnt_q == MAX : cnt_q == '0);
    assign out      = cnt_q;
    assign desborde = ovf_q;
endmodule

// File: tb/tb_contador_modulo_ud.sv
// tb_contador_modulo_ud: directed scoreboard bench for wrap, saturate, load/clear, flag and cascade behaviour.
module tb_contador_modulo_ud;
    typedef struct {
        int    sel;
        int    o;
        bit    t;
        bit    v;
        string nm;
    } exp_t;

    typedef struct {
        bit clr, ld, hab, dir, cd;
        int val, o;
        bit t, v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, c_rst;
    logic       a_hab, a_dir, a_clr, a_ld, a_cd;
    logic [3:0] a_val, a_out;
    logic       a_tc, a_ov;
    logic       b_hab, b_dir, b_clr, b_ld, b_cd;
    logic [3:0] b_val, b_out;
    logic       b_tc, b_ov;
    logic [3:0] lo_out, hi_out;
    logic       lo_tc, lo_ov, hi_tc, hi_ov;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    contador_modulo_ud #(.N(4), .MODULO(10), .SATURA(0)) u_a (
        .reloj(clk), .reset(rst_n), .habilitar(a_hab), .direccion(a_dir), .limpiar(a_clr),
        .cargar(a_ld), .valor_carga(a_val), .limpiar_desborde(a_cd),
        .out(a_out), .tc(a_tc), .desborde(a_ov));

    contador_modulo_ud #(.N(4), .MODULO(10), .SATURA(1)) u_b (
        .reloj(clk), .reset(rst_n), .habilitar(b_hab), .direccion(b_dir), .limpiar(b_clr),
        .cargar(b_ld), .valor_carga(b_val), .limpiar_desborde(b_cd),
        .out(b_out), .tc(b_tc), .desborde(b_ov));

    contador_modulo_ud #(.N(4), .MODULO(10), .SATURA(0)) u_lo (
        .reloj(clk), .reset(c_rst), .habilitar(1'b1), .direccion(1'b1), .limpiar(1'b0),
        .cargar(1'b0), .valor_carga(4'd0), .limpiar_desborde(1'b0),
        .out(lo_out), .tc(lo_tc), .desborde(lo_ov));

    contador_modulo_ud #(.N(4), .MODULO(10), .SATURA(0)) u_hi (
        .reloj(clk), .reset(c_rst), .habilitar(lo_tc), .direccion(1'b1), .limpiar(1'b0),
        .cargar(1'b0), .valor_carga(4'd0), .limpiar_desborde(1'b0),
        .out(hi_out), .tc(hi_tc), .desborde(hi_ov));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int sel, input int o, input bit t, input bit v, input string nm);
        exp_t e;
        e.sel = sel; e.o = o; e.t = t; e.v = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic drive(input int sel, input vec_t x, input string nm);
        if (sel == 0) begin
            a_clr = x.clr; a_ld = x.ld; a_hab = x.hab; a_dir = x.dir; a_cd = x.cd; a_val = 4'(x.val);
        end else begin
            b_clr = x.clr; b_ld = x.ld; b_hab = x.hab; b_dir = x.dir; b_cd = x.cd; b_val = 4'(x.val);
        end
        push(sel, x.o, x.t, x.v, nm);
    endtask

    // Monitor: entries describe the cycle just set up at the falling edge
    initial begin
        exp_t e;
        int   o, t, v;
        forever begin
            @(negedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    0:       begin o = a_out;  t = a_tc;  v = a_ov;  end
                    1:       begin o = b_out;  t = b_tc;  v = b_ov;  end
                    2:       begin o = lo_out; t = lo_tc; v = lo_ov; end
                    default: begin o = hi_out; t = hi_tc; v = hi_ov; end
                endcase
                chk({e.nm, ".out"}, o, e.o);
                chk({e.nm, ".tc"}, t, int'(e.t));
                chk({e.nm, ".desborde"}, v, int'(e.v));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t ta[15], tb_v[4];
        ta = '{
            '{1,0,1,0,0, 0,2,0,1}, '{0,0,1,0,0, 0,0,1,1}, '{0,0,1,0,0, 0,9,0,1},
            '{0,0,1,0,0, 0,8,0,1}, '{0,1,0,0,0,13,7,0,1}, '{1,1,0,0,0, 5,9,0,1},
            '{0,1,1,1,0, 4,0,0,1}, '{0,0,0,0,0, 0,4,0,1}, '{0,1,0,0,0, 5,4,0,1},
            '{0,0,0,0,1, 0,5,0,1}, '{0,1,0,0,0, 9,5,0,0}, '{0,0,1,1,0, 0,9,1,0},
            '{0,1,0,0,0, 9,0,0,1}, '{0,0,1,1,1, 0,9,1,1}, '{0,0,0,0,0, 0,0,0,1}};
        tb_v = '{
            '{0,0,1,0,0,0,9,0,1}, '{1,0,0,0,0,0,8,0,1},
            '{0,0,1,0,0,0,0,1,1}, '{0,0,0,0,0,0,0,0,1}};
        rst_n = 0; c_rst = 0;
        a_hab = 1; a_dir = 0; a_clr = 0; a_ld = 0; a_cd = 0; a_val = 0;
        b_hab = 0; b_dir = 1; b_clr = 0; b_ld = 0; b_cd = 0; b_val = 0;
        #1;
        chk("rst.out", a_out, 0);
        chk("rst.desborde", a_ov, 0);
        chk("rst.tc_down", a_tc, 1);
        a_dir = 1;
        #1;
        chk("rst.tc_up", a_tc, 0);
        fork
            begin
                @(negedge clk);
                rst_n = 1;
                for (int c = 0; c < 12; c++) begin
                    if (c > 0) @(negedge clk);
                    a_hab = 1; a_dir = 1;
                    push(0, c % 10, c % 10 == 9, c >= 10, $sformatf("a_up%0d", c));
                end
                for (int i = 0; i < 15; i++) begin
                    @(negedge clk);
                    drive(0, ta[i], $sformatf("a_vec%0d", i + 12));
                end
            end
            begin
                @(negedge clk);
                for (int c = 0; c < 12; c++) begin
                    if (c > 0) @(negedge clk);
                    b_hab = 1; b_dir = 1;
                    push(1, c < 9 ? c : 9, c >= 9, c >= 10, $sformatf("b_sat%0d", c));
                end
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    drive(1, tb_v[i], $sformatf("b_vec%0d", i + 12));
                end
            end
            begin
                for (int c = 0; c <= 123; c++) begin
                    @(negedge clk);
                    if (c == 0) c_rst = 1;
                    if (c inside {0, 5, 9, 10, 19, 20, 55, 99, 100, 123}) begin
                        push(2, c % 10, c % 10 == 9, c >= 10, $sformatf("lo%0d", c));
                        push(3, (c / 10) % 10, c % 100 == 99, c >= 100, $sformatf("hi%0d", c));
                    end
                end
                #2;
                c_rst = 0;
                #1;
                chk("async_rst.lo_out", lo_out, 0);
                chk("async_rst.hi_out", hi_out, 0);
                chk("async_rst.lo_desborde", lo_ov, 0);
                chk("async_rst.hi_desborde", hi_ov, 0);
            end
        join
        repeat (2) @(negedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
